// File: rtl/fft_bram_reader.sv
// fft_bram_reader: reads one stored multichannel FFT frame back from BRAM port B
// and emits one AXI4-Stream beat per bin, with every channel of that bin packed
// side by side (lane c = {im, re} at bits [2*SAMPLE_W*c +: 2*SAMPLE_W]).
// Optional build macro FFT_BRAM_RD_FMT_CHK_EN adds a sticky sign-extension
// checker on every captured word; without it fmt_err is tied low.
module fft_bram_reader #(
    parameter int unsigned NUM_CH    = 8,
    parameter int unsigned NUM_BINS  = 256,
    parameter int unsigned SAMPLE_W  = 24,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic [ADDR_W-1:0]            bram_addr,
    output logic                         bram_en,
    input  logic [31:0]                  bram_dout_re,
    input  logic [31:0]                  bram_dout_im,
    output logic [2*SAMPLE_W*NUM_CH-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic                         done,
    output logic                         fmt_err
);

    localparam int unsigned LANE_W = 2 * SAMPLE_W;
    localparam int unsigned DATA_W = LANE_W * NUM_CH;
    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BIN_W  = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

    localparam logic [CH_W-1:0]   LAST_CH    = CH_W'(NUM_CH - 1);
    localparam logic [BIN_W-1:0]  LAST_BIN   = BIN_W'(NUM_BINS - 1);
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(ADDR_STEP);
    localparam logic [1:0]        LAST_DRAIN = 2'(RD_LAT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDrain,
        StSend,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [BIN_W-1:0]    bin_q, bin_d;
    logic [CH_W-1:0]     ch_q, ch_d;         // channel currently being addressed
    logic [CH_W-1:0]     cap_q, cap_d;       // lane that takes the next returning word
    logic [1:0]          drain_q, drain_d;
    logic [RD_LAT-1:0]   rd_pipe_q, rd_pipe_d; // tracks reads in flight inside the BRAM
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                en_q, en_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                capture;
    logic [LANE_W-1:0]   lane_word;

    // A word leaves the read pipe exactly RD_LAT cycles after its address was shown.
    assign capture   = rd_pipe_q[RD_LAT-1];
    assign lane_word = {bram_dout_im[SAMPLE_W-1:0], bram_dout_re[SAMPLE_W-1:0]};

    // Next-state logic for the read sequencer and the registered stream outputs.
    always_comb begin
        state_d   = state_q;
        bin_d     = bin_q;
        ch_d      = ch_q;
        cap_d     = cap_q;
        drain_d   = drain_q;
        addr_d    = addr_q;
        en_d      = en_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rd_pipe_d = RD_LAT'({rd_pipe_q, state_q == StFetch});

        if (capture) begin
            data_d[cap_q*LANE_W +: LANE_W] = lane_word;
            cap_d = cap_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    bin_d   = '0;
                    ch_d    = '0;
                    cap_d   = '0;
                    addr_d  = '0;
                    en_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StFetch: begin
                if (ch_q == LAST_CH) begin
                    state_d = StDrain;
                    drain_d = '0;
                end else begin
                    ch_d   = ch_q + 1'b1;
                    addr_d = addr_q + STEP;
                end
            end
            StDrain: begin
                // The final lane lands on the same edge that raises tvalid.
                if (drain_q == LAST_DRAIN) begin
                    state_d = StSend;
                    en_d    = 1'b0;
                    valid_d = 1'b1;
                    last_d  = (bin_q == LAST_BIN);
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StSend: begin
                if (m_axis_tready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    if (bin_q == LAST_BIN) begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        addr_d  = '0;
                    end else begin
                        // Words are stored bin-major, so the next bin starts one step on.
                        state_d = StFetch;
                        bin_d   = bin_q + 1'b1;
                        ch_d    = '0;
                        cap_d   = '0;
                        addr_d  = addr_q + STEP;
                        en_d    = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; asynchronous reset abandons any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bin_q     <= '0;
            ch_q      <= '0;
            cap_q     <= '0;
            drain_q   <= '0;
            rd_pipe_q <= '0;
            addr_q    <= '0;
            en_q      <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_q     <= bin_d;
            ch_q      <= ch_d;
            cap_q     <= cap_d;
            drain_q   <= drain_d;
            rd_pipe_q <= rd_pipe_d;
            addr_q    <= addr_d;
            en_q      <= en_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bram_addr     = addr_q;
    assign bram_en       = en_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tvalid = valid_q;
    assign m_axis_tlast  = last_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef FFT_BRAM_RD_FMT_CHK_EN
    logic fmt_err_q, fmt_err_d;

    // A stored word is well formed when its upper bits replicate the sample sign bit.
    function automatic logic sext_ok(input logic [31:0] w);
        return w[31:SAMPLE_W] == {(32 - SAMPLE_W){w[SAMPLE_W-1]}};
    endfunction

    // Sticky error flag: cleared by an accepted start, set by any malformed capture.
    always_comb begin
        fmt_err_d = fmt_err_q;
        if (state_q == StIdle && start) begin
            fmt_err_d = 1'b0;
        end else if (capture && !(sext_ok(bram_dout_re) && sext_ok(bram_dout_im))) begin
            fmt_err_d = 1'b1;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fmt_err_q <= 1'b0;
        end else begin
            fmt_err_q <= fmt_err_d;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    // Upper word bits carry only sign extension and are dropped in this build.
    logic unused_dout_hi;
    assign unused_dout_hi = ^{bram_dout_re[31:SAMPLE_W], bram_dout_im[31:SAMPLE_W]};
    assign fmt_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fft_bram_reader.sv
// Bench for fft_bram_reader: BRAM port-B model, frame-level expected-beat model
// and one negedge compare process, driven by a short list of directed frames.
module tb_fft_bram_reader;

    localparam int unsigned NUM_CH    = 8;
    localparam int unsigned NUM_BINS  = 256;
    localparam int unsigned SAMPLE_W  = 24;
    localparam int unsigned ADDR_W    = 13;
    localparam int unsigned ADDR_STEP = 4;
    localparam int unsigned RD_LAT    = 1;
    localparam int unsigned LANE_W    = 2 * SAMPLE_W;
    localparam int unsigned DW        = LANE_W * NUM_CH;
    localparam int unsigned NW        = NUM_CH * NUM_BINS;
    localparam logic [ADDR_W-1:0] BAD_ADDR = ADDR_W'((10 * NUM_CH + 2) * ADDR_STEP);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] bram_addr;
    logic              bram_en;
    logic [31:0]       bram_dout_re;
    logic [31:0]       bram_dout_im;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              busy;
    logic              done;
    logic              fmt_err;

    always #5 clk = ~clk;

    fft_bram_reader #(
        .NUM_CH    (NUM_CH),
        .NUM_BINS  (NUM_BINS),
        .SAMPLE_W  (SAMPLE_W),
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_dout_re  (bram_dout_re),
        .bram_dout_im  (bram_dout_im),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .done          (done),
        .fmt_err       (fmt_err)
    );

    // BRAM port B: registered read, RD_LAT cycles from address to data.
    logic [31:0] mem_re  [NW];
    logic [31:0] mem_im  [NW];
    logic [31:0] pipe_re [RD_LAT];
    logic [31:0] pipe_im [RD_LAT];

    always @(posedge clk) begin
        if (bram_en) begin
            pipe_re[0] <= mem_re[bram_addr / ADDR_STEP];
            pipe_im[0] <= mem_im[bram_addr / ADDR_STEP];
        end
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_re[i] <= pipe_re[i-1];
            pipe_im[i] <= pipe_im[i-1];
        end
    end
    assign bram_dout_re = pipe_re[RD_LAT-1];
    assign bram_dout_im = pipe_im[RD_LAT-1];

    // Downstream ready: 0 = always ready, 1 = random ~30% duty, else held low.
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ($urandom_range(0, 9) < 3);
            default: m_axis_tready = 1'b0;
        endcase
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Test pattern: 24-bit {bin, ch, 0x0A5} sign-extended to 32 bits.
    function automatic logic [31:0] pat_re(input int b, input int c);
        logic [23:0] v;
        v = {b[7:0], c[3:0], 12'h0A5};
        return {{8{v[23]}}, v};
    endfunction

    // Expected beat for bin b: each lane is the low SAMPLE_W bits of im and re.
    function automatic logic [DW-1:0] exp_beat_data(input int b);
        logic [DW-1:0] d;
        logic [31:0]   wr;
        logic [31:0]   wi;
        d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr = mem_re[b*NUM_CH + c];
            wi = mem_im[b*NUM_CH + c];
            d[c*LANE_W +: LANE_W] = {wi[SAMPLE_W-1:0], wr[SAMPLE_W-1:0]};
        end
        return d;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Compare-process state.
    int            t0 = -100;
    int            exp_idx = 0;
    int            done_cnt = 0;
    int            issue_cyc = -1;
    int            rise_cyc = -1;
    logic          seen_valid = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_last = 1'b0;
    logic          prev_done = 1'b0;
    logic          prev_fmt = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW-1:0] beat0_data = '0;
    logic [DW-1:0] beat3_data = '0;

    // Checks every cycle against the frame-level model, sampled at the negedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_idx    = 0;
            seen_valid = 1'b0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (start && !busy && !done) begin
                t0         = cyc;
                exp_idx    = 0;
                seen_valid = 1'b0;
            end
            if (cyc == t0 + 1) begin
                check("busy_after_start", busy, 1);
                check("fmt_err_clear_on_start", fmt_err, 0);
            end
`ifndef FFT_BRAM_RD_FMT_CHK_EN
            check("fmt_err_tied_low", fmt_err, 0);
`endif
            if (bram_en && bram_addr == BAD_ADDR) issue_cyc = cyc;
            if (fmt_err && !prev_fmt) rise_cyc = cyc;
            prev_fmt = fmt_err;

            if (prev_stall) begin
                check("stall_tvalid", m_axis_tvalid, 1);
                check("stall_tdata", m_axis_tdata, prev_data);
                check("stall_tlast", m_axis_tlast, prev_last);
            end
            if (m_axis_tvalid) begin
                check("bram_en_in_send", bram_en, 0);
                if (!seen_valid) begin
                    seen_valid = 1'b1;
                    check("first_tvalid_latency", cyc - t0, 10);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_idx >= NUM_BINS) begin
                    check("beat_overrun", exp_idx, NUM_BINS - 1);
                end else begin
                    check("beat_tdata", m_axis_tdata, exp_beat_data(exp_idx));
                    check("beat_tlast", m_axis_tlast, exp_idx == NUM_BINS - 1);
                    if (exp_idx == 0) beat0_data = m_axis_tdata;
                    if (exp_idx == 3) beat3_data = m_axis_tdata;
                    exp_idx++;
                end
            end
            if (done) begin
                done_cnt++;
                check("done_width", prev_done, 0);
                check("done_busy_low", busy, 0);
                check("beats_per_frame", exp_idx, NUM_BINS);
            end
            prev_done  = done;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    // One frame: pulse start, optionally poke start at bins 5 and 200, await done.
    task automatic run_frame(input bit poke);
        int d0;
        int n;
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (done_cnt == d0 && n < 20000) begin
            @(posedge clk); #1;
            n++;
            start = poke && busy && (exp_idx == 5 || exp_idx == 200);
        end
        start = 1'b0;
        check("frame_done_seen", done_cnt - d0, 1);
        repeat (3) @(posedge clk);
        #1;
        check("idle_busy_low", busy, 0);
        check("idle_tvalid_low", m_axis_tvalid, 0);
        check("single_done_pulse", done_cnt - d0, 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got time limit, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] tmp;
        int            n;

        for (int b = 0; b < NUM_BINS; b++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mem_re[b*NUM_CH + c] = pat_re(b, c);
                mem_im[b*NUM_CH + c] = ~pat_re(b, c);
            end
        end
        mem_re[3*NUM_CH + 7] = 32'hFF800000;
        mem_im[3*NUM_CH + 7] = 32'h007FFFFF;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_bram_addr", bram_addr, 0);
        check("rst_bram_en", bram_en, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fmt_err", fmt_err, 0);
        rst_n = 1'b1;

        // Hand-computed pins on the model.
        tmp = exp_beat_data(0);
        check("model_b0_c0", tmp[47:0], 48'hFFFF5A_0000A5);
        tmp = exp_beat_data(255);
        check("model_b255_c5", tmp[5*LANE_W +: LANE_W], 48'h00AF5A_FF50A5);
        tmp = exp_beat_data(3);
        check("model_b3_c7", tmp[DW-1 -: LANE_W], 48'h7FFFFF_800000);

        // Frame 1: always ready.
        ready_mode = 0;
        run_frame(1'b0);
        check("beat3_lane7", beat3_data[DW-1 -: LANE_W], 48'h7FFFFF_800000);
        check("beat0_lane0", beat0_data[47:0], 48'hFFFF5A_0000A5);
        check("fmt_err_clean_frame", fmt_err, 0);

        // Frame 2: random backpressure.
        ready_mode = 1;
        run_frame(1'b0);

        // Frame 3: start pokes mid-frame are ignored; frame 4 follows after done.
        ready_mode = 0;
        run_frame(1'b1);
        run_frame(1'b0);

        // Reset while stalled in SEND at bin 100.
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (exp_idx < 100 && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        ready_mode = 2;
        n = 0;
        while (!m_axis_tvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stalled_at_bin", exp_idx, 100);
        check("stalled_tvalid", m_axis_tvalid, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midreset_tvalid", m_axis_tvalid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_bram_en", bram_en, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        ready_mode = 0;
        beat0_data = '0;
        run_frame(1'b0);
        check("post_reset_beat0", beat0_data[47:0], 48'hFFFF5A_0000A5);

`ifdef FFT_BRAM_RD_FMT_CHK_EN
        // Malformed word at bin 10 ch 2: flag rises one cycle after capture, stays set.
        mem_re[10*NUM_CH + 2] = 32'h00800000;
        run_frame(1'b0);
        check("fmt_err_rise_latency", rise_cyc - issue_cyc, RD_LAT + 1);
        check("fmt_err_sticky", fmt_err, 1);
        mem_re[10*NUM_CH + 2] = pat_re(10, 2);
        run_frame(1'b0);
        check("fmt_err_after_clean", fmt_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_bram_reader.md
Name: fft_bram_reader

Overview:
- Read-back counterpart of the FFT-to-BRAM writer. After the writer signals its frame-complete finish pulse, this block reads the stored multichannel spectrum from BRAM port B.
- It repacks each frequency bin's NUM_CH complex samples into one wide AXI4-Stream beat for downstream spatial processing (beamformer/DOA).
- One start produces exactly NUM_BINS beats, with tlast on the final beat.

Parameters:
- NUM_CH, 8, channels (microphones) per bin.
- NUM_BINS, 256, FFT bins per frame.
- SAMPLE_W, 24, width of re/im component in the output beat.
- ADDR_W, 13, BRAM byte-address width.
- ADDR_STEP, 4, byte-address increment per BRAM word.
- RD_LAT, 1, BRAM read latency in cycles (1 or 2 supported).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch one frame read; sampled only in IDLE.
- bram_addr  out  ADDR_W  byte address to BRAM port B.
- bram_en  out  1  BRAM port B enable.
- bram_dout_re  in  32  real word (sign-extended 24-bit) from BRAM.
- bram_dout_im  in  32  imag word from BRAM.
- m_axis_tdata  out  2*SAMPLE_W*NUM_CH  packed bin: lane c = {im[23:0], re[23:0]} at bits [48c+47:48c].
- m_axis_tvalid  out  1  beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last bin of frame.
- busy  out  1  frame read in progress.
- done  out  1  one-cycle pulse after final beat accepted.
- fmt_err  out  1  sticky format error (see Optional Feature).

Behaviour:
- Reset values: all outputs 0 (bram_addr, bram_en, tdata, tvalid, tlast, busy, done, fmt_err). Internal bin and channel counters are 0. State is IDLE.
- Address map: the word for bin b, channel c is at byte address (b*NUM_CH + c)*ADDR_STEP. Base is 0. With the defaults, the last word is 0x1FFC.
- FSM states: IDLE, FETCH, DRAIN, SEND, DONE.
- IDLE:
  - start=1 at edge t0 → FETCH; busy=1 from t0+1.
  - bin counter cleared.
- FETCH:
  - Runs for NUM_CH cycles, presenting addresses for c=0..NUM_CH-1 of the current bin on consecutive cycles (t0+1..t0+8 for the first bin).
  - bram_en=1.
  - Then → DRAIN.
- Capture: data for the address presented in cycle k is captured at edge k+RD_LAT. Low SAMPLE_W bits of re/im go into lane c of a holding register; upper bits are discarded.
- DRAIN:
  - Lasts RD_LAT cycles until the last lane is captured; bram_en stays 1.
  - Then → SEND with tvalid=1.
  - First tvalid with defaults is at cycle t0+10.
- SEND:
  - tvalid held high; tdata and tlast stay stable until tready=1.
  - tlast=1 only when bin == NUM_BINS-1.
  - On handshake with a non-last bin: bin+1, tvalid=0 next cycle, → FETCH.
  - On handshake with the last bin: → DONE.
- DONE: done=1 for exactly one cycle; busy=0; → IDLE.
- Throughput: at most one beat per NUM_CH+RD_LAT+1 cycles. No prefetch overlap.
- start while not in IDLE is ignored.
- tready is ignored outside SEND. tvalid never depends combinationally on tready.
- Reset asserted mid-frame: immediate return to IDLE, all outputs 0, partial frame abandoned. The next start re-reads from bin 0.
- bram_en=0 in IDLE, SEND and DONE.

Optional Feature:
- Macro: FFT_BRAM_RD_FMT_CHK_EN.
- Defined:
  - Each captured word is checked for bits [31:SAMPLE_W] all equal to bit [SAMPLE_W-1], i.e. a valid sign extension. Checked on both re and im.
  - Any violation sets fmt_err=1 at the capture edge+1.
  - fmt_err is sticky until the next accepted start (cleared at t0+1) or reset. Data is still forwarded truncated.
- Undefined: no checker logic; fmt_err tied to 0.

Test Plan:
- Preload word(b,c).re = sign-extended {b[7:0], c[3:0], 12'h0A5} and im = ~re; pulse start → exactly 256 beats. Beat b, lane c carries those values; tlast only on beat 255; tvalid first at t0+10; one done pulse; busy low afterwards.
- Same frame with tready random at 30% duty → identical beat sequence; tdata/tlast unchanged during every stall cycle; bram_en=0 during SEND stalls.
- re word 32'hFF800000, im word 32'h007FFFFF at bin 3 ch 7 → beat 3 bits [383:336] = {24'h7FFFFF, 24'h800000}.
- start pulsed at bins 5 and 200 while busy → no restart, 256 beats total. start after done → full second frame identical to the first.
- rst_n low for 2 cycles while in SEND at bin 100 → tvalid=0 and busy=0 immediately. Next start yields beat 0 = bin 0 data.
- With FFT_BRAM_RD_FMT_CHK_EN, word 32'h00800000 at bin 10 ch 2 → fmt_err=1 from the following cycle, held until the next start. Without the macro, fmt_err stays 0.
